alu_arbiter: RTL

Shares one 32-bit ALU datapath between two requesters. Round-robin arbitration, a valid/ready request handshake and a three-state sequencer. The ALU is a combinational core built from the team's bitwise and arithmetic slices (including `xor32bit`). Operands are captured, executed in a registered cycle, and the result and flags are returned to the granted requester with a one-cycle response pulse. The block sits between the two operand sources of the 32-bit ALU design and the shared ALU core.

---
 rtl/alu_arbiter_pkg.sv | 24 ++
 rtl/alu_arbiter_if.sv | 38 +++
 rtl/alu_arbiter_core.sv | 63 ++++++
 rtl/alu_arbiter.sv | 108 ++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: datapath width,
// opcode encodings and sequencer state encodings.
package alu_arbiter_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [2:0] {
        ALU_AND   = 3'b000,
        ALU_OR    = 3'b001,
        ALU_XOR   = 3'b010,
        ALU_ADD   = 3'b011,
        ALU_SUB   = 3'b100,
        ALU_NOR   = 3'b101,
        ALU_SLT   = 3'b110,
        ALU_PASSB = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two operand sources and the arbiter.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(parameter int WIDTH = 32);

    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp0_valid;
    logic             rsp1_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic             rsp_carry;
    logic             busy;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data, rsp_zero, rsp_carry, busy
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data, rsp_zero, rsp_carry, busy
    );

endinterface

// File: rtl/alu_arbiter_core.sv
// Combinational ALU core shared by both requesters, plus the bitwise XOR
// slice it uses for the XOR path.
module xor32bit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign y[gi] = a[gi] ^ b[gi];
        end
    endgenerate

endmodule

module alu32_core
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic [WIDTH-1:0] xor_y;
    logic             slt_bit;

    xor32bit #(.WIDTH(WIDTH)) u_xor (
        .a (a),
        .b (b),
        .y (xor_y)
    );

    // Subtraction as a + ~b + 1 so the top bit reads directly as no-borrow.
    assign add_sum = {1'b0, a} + {1'b0, b};
    assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign slt_bit = $signed(a) < $signed(b);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = xor_y;
            ALU_ADD:   begin result = add_sum[WIDTH-1:0]; carry = add_sum[WIDTH]; end
            ALU_SUB:   begin result = sub_sum[WIDTH-1:0]; carry = sub_sum[WIDTH]; end
            ALU_NOR:   result = ~(a | b);
            ALU_SLT:   result = {{(WIDTH-1){1'b0}}, slt_bit};
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU core between two requesters through a
// three-state IDLE/EXEC/RESP sequencer.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = alu_arbiter_pkg::ALU_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    alu_arbiter_if.slave bus
);

    state_t           state_reg;
    logic             ptr_reg;
    logic             gnt_reg;
    alu_op_t          op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             rsp0_valid_reg;
    logic             rsp1_valid_reg;
    logic [WIDTH-1:0] rsp_data_reg;
    logic             rsp_zero_reg;
    logic             rsp_carry_reg;

    logic             grant_next;
    logic             accept;
    alu_op_t          op_next;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;

    // Pointer only breaks ties; a lone valid requester always wins.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            grant_next = ptr_reg;
        end else begin
            grant_next = bus.req1_valid;
        end
    end

    assign accept         = (state_reg == IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
    assign bus.req0_ready = accept && !grant_next;
    assign bus.req1_ready = accept && grant_next;

    assign op_next = grant_next ? alu_op_t'(bus.req1_op) : alu_op_t'(bus.req0_op);
    assign a_next  = grant_next ? bus.req1_a : bus.req0_a;
    assign b_next  = grant_next ? bus.req1_b : bus.req0_b;

    alu32_core #(.WIDTH(WIDTH)) u_core (
        .op     (op_reg),
        .a      (a_reg),
        .b      (b_reg),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            ptr_reg        <= 1'b0;
            gnt_reg        <= 1'b0;
            op_reg         <= ALU_AND;
            a_reg          <= '0;
            b_reg          <= '0;
            rsp0_valid_reg <= 1'b0;
            rsp1_valid_reg <= 1'b0;
            rsp_data_reg   <= '0;
            rsp_zero_reg   <= 1'b0;
            rsp_carry_reg  <= 1'b0;
        end else begin
            rsp0_valid_reg <= 1'b0;
            rsp1_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        gnt_reg   <= grant_next;
                        op_reg    <= op_next;
                        a_reg     <= a_next;
                        b_reg     <= b_next;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_reg   <= alu_result;
                    rsp_zero_reg   <= (alu_result == '0);
                    rsp_carry_reg  <= alu_carry;
                    rsp0_valid_reg <= !gnt_reg;
                    rsp1_valid_reg <= gnt_reg;
                    state_reg      <= RESP;
                end
                RESP: begin
                    ptr_reg   <= !gnt_reg;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.rsp0_valid = rsp0_valid_reg;
    assign bus.rsp1_valid = rsp1_valid_reg;
    assign bus.rsp_data   = rsp_data_reg;
    assign bus.rsp_zero   = rsp_zero_reg;
    assign bus.rsp_carry  = rsp_carry_reg;
    assign bus.busy       = (state_reg != IDLE);

endmodule
